// File: rtl/logit_seq_ctrl.sv
// Buffers one frame of signed CNN logits and presents them one at a time on the HPS logit PIO, using a toggle-phase ack.
// Optional build macro LOGIT_ARGMAX_EN adds a running signed argmax of each frame on argmax_word.
module logit_seq_ctrl #(
  parameter int NUM_LOGITS = 10,
  parameter int DATA_W     = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cnn_logit_valid,
  input  logic [DATA_W-1:0] cnn_logit_data,
  output logic              cnn_ready,
  input  logic              hps_ack,
  output logic [31:0]       pio_word,
  output logic [31:0]       argmax_word
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_LOGITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        wr_idx_q, wr_idx_d;
  logic [3:0]        rd_idx_q, rd_idx_d;
  logic              phase_q, phase_d;
  logic              overrun_q, overrun_d;
  logic [31:0]       pio_word_q, pio_word_d;
  logic [DATA_W-1:0] buf_q [NUM_LOGITS];

  logic accept;
  logic ack;

  // Ready is a pure state decode so the accelerator never sees a combinational path from its own valid.
  assign cnn_ready = (state_q != PRESENT);
  assign accept    = cnn_logit_valid & cnn_ready;
  assign ack       = (state_q == PRESENT) && (hps_ack == phase_q);
  assign pio_word  = pio_word_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    phase_d   = phase_q;
    overrun_d = overrun_q | (cnn_logit_valid & ~cnn_ready);

    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (wr_idx_q == LAST_IDX) begin
            state_d  = PRESENT;
            wr_idx_d = '0;
          end else begin
            state_d  = FILL;
            wr_idx_d = wr_idx_q + 4'd1;
          end
        end
      end
      PRESENT: begin
        // Phase toggles even on the last ack, so a held ack level cannot consume the next frame's entry 0.
        if (ack) begin
          phase_d = ~phase_q;
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Entry 0 is never written on the frame's final accept (NUM_LOGITS >= 2), so buf_q is already current here.
    if (state_d == PRESENT) begin
      pio_word_d = {1'b1, phase_d, (rd_idx_d == LAST_IDX), overrun_d, rd_idx_d, buf_q[rd_idx_d]};
    end else begin
      pio_word_d = {1'b0, phase_d, 1'b0, overrun_d, 4'b0, 24'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      phase_q    <= 1'b1;
      overrun_q  <= 1'b0;
      pio_word_q <= 32'h4000_0000;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      phase_q    <= phase_d;
      overrun_q  <= overrun_d;
      pio_word_q <= pio_word_d;
    end
  end

  // NOTE: the logit buffer is not reset; every entry is rewritten before it can be presented.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[wr_idx_q] <= cnn_logit_data;
    end
  end

`ifdef LOGIT_ARGMAX_EN
  logic signed [DATA_W-1:0] max_val_q, max_val_d;
  logic [3:0]               max_idx_q, max_idx_d;
  logic [31:0]              argmax_word_q, argmax_word_d;

  always_comb begin
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    // Strictly-greater replacement keeps ties on the lowest index.
    if (accept && ((wr_idx_q == 4'd0) || ($signed(cnn_logit_data) > max_val_q))) begin
      max_val_d = $signed(cnn_logit_data);
      max_idx_d = wr_idx_q;
    end
    argmax_word_d = (state_d == PRESENT) ? {1'b1, 27'b0, max_idx_d} : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_val_q     <= '0;
      max_idx_q     <= '0;
      argmax_word_q <= '0;
    end else begin
      max_val_q     <= max_val_d;
      max_idx_q     <= max_idx_d;
      argmax_word_q <= argmax_word_d;
    end
  end

  assign argmax_word = argmax_word_q;
`else
  assign argmax_word = 32'h0;
`endif

endmodule

// File: tb/tb_logit_seq_ctrl.sv
// Directed bench for logit_seq_ctrl: fill, toggle-ack drain, held ack, overrun, argmax and mid-frame reset.
module tb_logit_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cnn_logit_valid;
  logic [23:0] cnn_logit_data;
  logic        cnn_ready;
  logic        hps_ack;
  logic [31:0] pio_word;
  logic [31:0] argmax_word;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] f2 [10] = '{24'hFFFFFB, 24'h000007, 24'h000003, 24'h000007, 24'hFFFF9C,
                           24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, 24'hFFFFFA, 24'hFFFFFF};

  logit_seq_ctrl #(.NUM_LOGITS(10), .DATA_W(24)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cnn_logit_valid (cnn_logit_valid),
    .cnn_logit_data  (cnn_logit_data),
    .cnn_ready       (cnn_ready),
    .hps_ack         (hps_ack),
    .pio_word        (pio_word),
    .argmax_word     (argmax_word)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic v, input logic ph, input logic last,
                                       input logic ovr, input logic [3:0] idx, input logic [23:0] d);
    return {v, ph, last, ovr, idx, d};
  endfunction

  task automatic push(input logic [23:0] d);
    cnn_logit_valid = 1'b1;
    cnn_logit_data  = d;
    step();
  endtask

  initial begin
    logic        p;
    logic [23:0] d;
    logic [31:0] am_exp;

    reset_n = 1'b0; cnn_logit_valid = 1'b0; cnn_logit_data = '0; hps_ack = 1'b0;
    repeat (3) step();
    check("reset_pio", pio_word, 32'h4000_0000);
    check("reset_ready", {31'b0, cnn_ready}, 32'd1);
    check("reset_argmax", argmax_word, 32'h0);
    reset_n = 1'b1;
    step();
    check("idle_pio", pio_word, 32'h4000_0000);

    // Frame 1: logits 0..9 back to back.
    for (int i = 0; i < 10; i++) begin
      push(24'(i));
      if (i == 8) check("ready_before_last", {31'b0, cnn_ready}, 32'd1);
    end
    cnn_logit_valid = 1'b0;
    check("f1_ready_drop", {31'b0, cnn_ready}, 32'd0);
    check("f1_entry0", pio_word, 32'hC000_0000);

    // Drain with immediate toggle acks.
    p = 1'b1;
    for (int e = 0; e < 10; e++) begin
      d = 24'(e);
      check($sformatf("f1_entry%0d", e), pio_word, word(1'b1, p, e == 9, 1'b0, 4'(e), d));
      hps_ack = p;
      step();
      p = ~p;
    end
    check("f1_done_pio", pio_word, 32'h4000_0000);
    check("f1_done_ready", {31'b0, cnn_ready}, 32'd1);
    check("f1_done_argmax", argmax_word, 32'h0);

    // Frame 2: signed values for argmax; accepted straight after the final ack.
    for (int i = 0; i < 10; i++) push(f2[i]);
    cnn_logit_valid = 1'b0;
    check("f2_entry0", pio_word, 32'hC0FF_FFFB);
`ifdef LOGIT_ARGMAX_EN
    am_exp = 32'h8000_0001;
`else
    am_exp = 32'h0;
`endif
    check("f2_argmax", argmax_word, am_exp);

    // Held ack must freeze the entry.
    repeat (50) step();
    check("hold_pio", pio_word, 32'hC0FF_FFFB);

    // Logit offered while presenting is dropped and flags overrun.
    push(24'h123456);
    cnn_logit_valid = 1'b0;
    check("overrun_pio", pio_word, 32'hD0FF_FFFB);
    check("overrun_ready", {31'b0, cnn_ready}, 32'd0);

    p = 1'b1;
    hps_ack = p;
    step();
    p = ~p;
    check("toggle_one", pio_word, 32'h9100_0007);
    step();
    check("toggle_only_one", pio_word, 32'h9100_0007);
    for (int e = 1; e < 10; e++) begin
      check($sformatf("f2_entry%0d", e), pio_word, word(1'b1, p, e == 9, 1'b1, 4'(e), f2[e]));
      hps_ack = p;
      step();
      p = ~p;
    end
    check("f2_done_pio", pio_word, 32'h5000_0000);
    check("f2_done_argmax", argmax_word, 32'h0);

    // Frame 3: drain to entry 4, then reset mid-frame.
    for (int i = 0; i < 10; i++) push(24'h100 + 24'(i));
    cnn_logit_valid = 1'b0;
    p = 1'b1;
    for (int e = 0; e < 4; e++) begin
      hps_ack = p;
      step();
      p = ~p;
    end
    check("f3_entry4", pio_word, 32'hD400_0104);
    reset_n = 1'b0;
    #1;
    check("midreset_pio", pio_word, 32'h4000_0000);
    check("midreset_ready", {31'b0, cnn_ready}, 32'd1);
    check("midreset_argmax", argmax_word, 32'h0);
    step();
    reset_n = 1'b1;
    hps_ack = 1'b0;
    step();

    // Frame 4 must start at index 0 with overrun cleared.
    for (int i = 0; i < 10; i++) push(24'hA0 + 24'(i));
    cnn_logit_valid = 1'b0;
    check("f4_entry0", pio_word, 32'hC000_00A0);
`ifdef LOGIT_ARGMAX_EN
    am_exp = 32'h8000_0009;
`else
    am_exp = 32'h0;
`endif
    check("f4_argmax", argmax_word, am_exp);
    hps_ack = 1'b1;
    step();
    check("f4_entry1", pio_word, 32'h8100_00A1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
